// File: rtl/axi_s0_pkg.sv
// Shared definitions for the s0 AXI slave port, used by both the read- and write-channel FSMs.
// Holds state encodings, burst/response codes and default bus widths.
package axi_s0_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;

  typedef enum logic [3:0] {
    ST_INIT     = 4'b0001,
    ST_AW_READY = 4'b0010,
    ST_W_DATA   = 4'b0100,
    ST_B_RESP   = 4'b1000
  } wr_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only FIXED and INCR are accepted; WRAP and the reserved code 2'b11 get SLVERR.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Beat address register for the s0 write channel.
// Loads the AW address and advances it per accepted beat for INCR bursts only.
module axi_wr_addr_gen
  import axi_s0_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              step,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else if (clear) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= load_addr;
    end else if (step && (burst == BURST_INCR)) begin
      // Wraps naturally at 2^ADDR_W.
      addr_q <= addr_q + (ADDR_W'(1) << size);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/axi_wr_fsm.sv
// AXI4 write-channel slave controller for port s0: one burst at a time, W beats pushed
// straight into the input FIFO, one B response per burst.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_INIT     | after reset; clears burst registers, no handshakes
// ST_AW_READY | idle, awready high, waiting for a write address
// ST_W_DATA   | burst open, accepting W beats while the FIFO has room
// ST_B_RESP   | bvalid high with registered id/resp, waiting for bready
module axi_wr_fsm
  import axi_s0_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ID_W-1:0]   axs_s0_awid,
  input  logic [ADDR_W-1:0] axs_s0_awaddr,
  input  logic [7:0]        axs_s0_awlen,
  input  logic [2:0]        axs_s0_awsize,
  input  logic [1:0]        axs_s0_awburst,
  input  logic              axs_s0_awvalid,
  output logic              axs_s0_awready,
  input  logic              axs_s0_wlast,
  input  logic              axs_s0_wvalid,
  output logic              axs_s0_wready,
  output logic [ID_W-1:0]   axs_s0_bid,
  output logic [1:0]        axs_s0_bresp,
  output logic              axs_s0_bvalid,
  input  logic              axs_s0_bready,
  input  logic              in_fifo_full,
  output logic              in_fifo_push,
  output logic [ADDR_W-1:0] wr_addr
);

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [7:0]        remaining_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              aw_acc;
  logic              beat_acc;
  logic              last_beat;
  logic              addr_clear;
  logic              addr_step;

  assign aw_acc    = (state_q == ST_AW_READY) && axs_s0_awvalid;
  assign beat_acc  = (state_q == ST_W_DATA) && axs_s0_wvalid && !in_fifo_full;
  // A burst ends on the counted final beat or on an early wlast, whichever comes first.
  assign last_beat = (remaining_q == 8'd0) || axs_s0_wlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:     state_d = ST_AW_READY;
      ST_AW_READY: if (axs_s0_awvalid) state_d = ST_W_DATA;
      ST_W_DATA:   if (beat_acc && last_beat) state_d = ST_B_RESP;
      ST_B_RESP:   if (axs_s0_bready) state_d = ST_AW_READY;
      default:     state_d = ST_INIT;
    endcase
  end

  always_comb begin
    axs_s0_awready = 1'b0;
    axs_s0_wready  = 1'b0;
    in_fifo_push   = 1'b0;
    axs_s0_bvalid  = 1'b0;
    axs_s0_bid     = '0;
    axs_s0_bresp   = RESP_OKAY;
    addr_clear     = 1'b0;
    addr_step      = 1'b0;
    case (state_q)
      ST_INIT: addr_clear = 1'b1;
      ST_AW_READY: axs_s0_awready = 1'b1;
      ST_W_DATA: begin
        axs_s0_wready = !in_fifo_full;
        in_fifo_push  = beat_acc;
        addr_step     = beat_acc && !last_beat;
      end
      ST_B_RESP: begin
        axs_s0_bvalid = 1'b1;
        axs_s0_bid    = id_q;
        axs_s0_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q        <= '0;
      remaining_q <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
    end else if (state_q == ST_INIT) begin
      id_q        <= '0;
      remaining_q <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
    end else if (aw_acc) begin
      id_q        <= axs_s0_awid;
      remaining_q <= axs_s0_awlen;
      size_q      <= axs_s0_awsize;
      burst_q     <= axs_s0_awburst;
      err_q       <= !burst_supported(axs_s0_awburst);
    end else if (beat_acc) begin
      if (!last_beat) begin
        remaining_q <= remaining_q - 8'd1;
      end else if ((remaining_q == 8'd0) != axs_s0_wlast) begin
        // Missing wlast on the counted last beat, or wlast before it.
        err_q <= 1'b1;
      end
    end
  end

  axi_wr_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (addr_clear),
    .load      (aw_acc),
    .load_addr (axs_s0_awaddr),
    .step      (addr_step),
    .size      (size_q),
    .burst     (burst_q),
    .addr      (wr_addr)
  );

endmodule
